map_access_arbiter: RTL and testbench
=====================================

Name: map_access_arbiter

Overview:
- Owns the single-port map RAM that holds per-grid-cell terrain (64 x 44 game grid, 2 bits per cell).
- Shares the RAM between three clients: the VGA renderer's tile fetch, which has absolute priority while the renderer is busy, and two tank/shell game-logic requesters, which are served round-robin only during vertical blanking.
- Also sequences map initialisation, writing the border walls on reset and on each new round.

Parameters:
- MAP_W, 64, grid columns; x is 6 bits.
- MAP_H, 44, playable grid rows; y is 6 bits, and rows >= MAP_H are out of range.
- ADDR_W, 12, RAM address width; address = {y[5:0], x[5:0]}.

Ports:
- clk  in  1  system clock (pixel clock domain)
- rst  in  1  synchronous, active-high reset
- i_clear  in  1  one-cycle pulse; re-runs map initialisation
- o_init_done  out  1  high once initialisation has completed
- i_vga_busy  in  1  renderer is in its active-line window
- i_vga_x  in  6  renderer tile request, column
- i_vga_y  in  6  renderer tile request, row
- o_vga_is_wall  out  1  wall flag for the requested tile
- i_p1_valid  in  1  requester 1 access request
- i_p1_we  in  1  1 = write, 0 = read
- i_p1_x  in  6  requester 1 column
- i_p1_y  in  6  requester 1 row
- i_p1_wdata  in  2  requester 1 write data
- o_p1_ready  out  1  request accepted this cycle
- o_p1_rvalid  out  1  read data valid
- o_p1_rdata  out  2  read data
- i_p2_*, o_p2_*  same as p1  requester 2
- o_mem_addr  out  12  RAM address
- o_mem_we  out  1  RAM write enable
- o_mem_wdata  out  2  RAM write data
- i_mem_rdata  in  2  RAM read data; arrives 1 cycle after the address

Behaviour:
- Reset (rst sampled high at a clk edge):
  - state = S_INIT, init address = 0, round-robin pointer = "p2 last granted".
  - o_init_done, o_vga_is_wall, o_p*_ready, o_p*_rvalid, o_mem_we = 0; o_p*_rdata = 0.
- Reset mid-operation: any in-flight grant is abandoned, no rvalid is emitted, and initialisation restarts at address 0.
- Cell encoding: 00 empty, 01 wall, 10/11 reserved (stored and returned unchanged).
- FSM has two states: S_INIT and S_RUN.
- S_INIT:
  - Writes one address per cycle, 0..4095, ignoring i_vga_busy.
  - Write data is 01 if x==0, x==MAP_W-1, y==0 or y==MAP_H-1 (with y < MAP_H); otherwise 00. Rows y >= MAP_H are written 00.
  - Game requests are not accepted (ready = 0).
  - o_vga_is_wall is forced 0.
  - After address 4095 is written: go to S_RUN and set o_init_done the next cycle. Total 4096 cycles.
- i_clear in S_RUN: clear o_init_done and enter S_INIT at address 0 next cycle. Any rvalid already due from the final S_RUN grant is still emitted one cycle later. i_clear in S_INIT restarts the count at 0.
- S_RUN, i_vga_busy = 1:
  - o_mem_addr = {i_vga_y, i_vga_x}, o_mem_we = 0.
  - o_vga_is_wall <= (i_mem_rdata == 01), registered. Total latency from i_vga_x/y to o_vga_is_wall is 2 clk.
  - No game grants are issued.
- S_RUN, i_vga_busy = 0:
  - At most one game grant per cycle.
  - If exactly one requester is valid, it is granted.
  - If both are valid, the requester not granted last wins, and the pointer updates on each grant.
  - Granted requester: o_pN_ready = 1 in the same cycle (combinational from valid), and its address/we/wdata drive the RAM.
  - Requesters hold valid, we, x, y and wdata stable until ready.
- Read grant: o_pN_rvalid = 1 exactly one cycle after ready, with o_pN_rdata = i_mem_rdata. Back-to-back grants are allowed, so rvalid may pulse every cycle.
- Out-of-range coordinate (y >= MAP_H):
  - Still acknowledged with ready.
  - Write: suppressed (o_mem_we = 0).
  - Read: returns rdata 00 with normal rvalid timing.
- i_vga_busy rising in the same cycle as a game valid: the VGA path wins and the game request waits. An rvalid already due is still emitted.
- o_vga_is_wall holds its last value while i_vga_busy = 0.

Test Plan:
- Reset then idle 4096 cycles -> o_init_done rises on cycle 4097. Reading (0,5) returns 01, (10,10) returns 00, (63,43) returns 01, (5,44) returns 00.
- After init, i_vga_busy=1, vga (0,0) then (10,10) -> o_vga_is_wall = 1 two cycles after (0,0) is presented, then 0 two cycles after (10,10).
- i_vga_busy=0, p1 writes 01 at (20,20), then p2 reads (20,20) -> p1 ready in the same cycle; p2 rvalid with rdata 01 one cycle after its ready.
- Both p1 and p2 valid with reads held for 4 cycles -> grants alternate p1, p2, p1, p2 (p1 first after reset); each rvalid lags its ready by 1.
- p1 valid while i_vga_busy=1 for 100 cycles -> o_p1_ready stays 0; granted on the first cycle i_vga_busy=0.
- i_clear mid-run after writing (20,20)=01 -> o_init_done drops the next cycle, and game ready stays 0 for 4096 cycles. (20,20) then reads 00. p1 write to (5,50) is acknowledged with no RAM write.

Source files
------------

// File: rtl/map_access_arbiter.sv
// Map RAM owner: sequences border-wall initialisation, then shares the single RAM port
// between the VGA tile fetch (priority while busy) and two round-robin game requesters.
module map_access_arbiter #(
  parameter int MAP_W  = 64,
  parameter int MAP_H  = 44,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clear,
  output logic              o_init_done,
  input  logic              i_vga_busy,
  input  logic [5:0]        i_vga_x,
  input  logic [5:0]        i_vga_y,
  output logic              o_vga_is_wall,
  input  logic              i_p1_valid,
  input  logic              i_p1_we,
  input  logic [5:0]        i_p1_x,
  input  logic [5:0]        i_p1_y,
  input  logic [1:0]        i_p1_wdata,
  output logic              o_p1_ready,
  output logic              o_p1_rvalid,
  output logic [1:0]        o_p1_rdata,
  input  logic              i_p2_valid,
  input  logic              i_p2_we,
  input  logic [5:0]        i_p2_x,
  input  logic [5:0]        i_p2_y,
  input  logic [1:0]        i_p2_wdata,
  output logic              o_p2_ready,
  output logic              o_p2_rvalid,
  output logic [1:0]        o_p2_rdata,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic              o_mem_we,
  output logic [1:0]        o_mem_wdata,
  input  logic [1:0]        i_mem_rdata
);

  typedef enum logic [0:0] {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam logic [5:0]        X_LAST    = 6'(MAP_W - 1);
  localparam logic [5:0]        Y_LAST    = 6'(MAP_H - 1);
  localparam logic [5:0]        Y_LIMIT   = 6'(MAP_H);
  localparam logic [ADDR_W-1:0] ADDR_LAST = {ADDR_W{1'b1}};
  localparam logic [1:0]        CELL_EMPTY = 2'b00;
  localparam logic [1:0]        CELL_WALL  = 2'b01;

  state_t              state_r;
  state_t              state_s;
  logic [ADDR_W-1:0]   init_addr_r;
  logic                init_done_r;
  logic                vga_is_wall_r;
  logic                vga_pend_r;
  logic                last_p2_r;
  logic                p1_rv_r;
  logic                p2_rv_r;
  logic                p1_oor_r;
  logic                p2_oor_r;

  logic                grant_ok_s;
  logic                p1_gnt_s;
  logic                p2_gnt_s;
  logic                p1_oor_s;
  logic                p2_oor_s;
  logic [ADDR_W-1:0]   mem_addr_s;
  logic                mem_we_s;
  logic [1:0]          mem_wdata_s;

  // Initial terrain: walls on the playfield border, rows beyond the playfield left empty.
  function automatic logic [1:0] init_cell(input logic [ADDR_W-1:0] addr);
    logic [5:0] cx;
    logic [5:0] cy;
    cx = addr[5:0];
    cy = addr[11:6];
    if ((cy < Y_LIMIT) && ((cx == 6'd0) || (cx == X_LAST) || (cy == 6'd0) || (cy == Y_LAST))) begin
      return CELL_WALL;
    end else begin
      return CELL_EMPTY;
    end
  endfunction

  assign p1_oor_s   = (i_p1_y >= Y_LIMIT);
  assign p2_oor_s   = (i_p2_y >= Y_LIMIT);
  assign grant_ok_s = (state_r == S_RUN) && !i_vga_busy && !rst;

  // Next state, game grant selection and RAM port mux.
  always_comb begin
    state_s     = state_r;
    p1_gnt_s    = 1'b0;
    p2_gnt_s    = 1'b0;
    mem_addr_s  = {ADDR_W{1'b0}};
    mem_we_s    = 1'b0;
    mem_wdata_s = CELL_EMPTY;

    if (grant_ok_s) begin
      if (i_p1_valid && i_p2_valid) begin
        p1_gnt_s = last_p2_r;
        p2_gnt_s = !last_p2_r;
      end else begin
        p1_gnt_s = i_p1_valid;
        p2_gnt_s = i_p2_valid;
      end
    end else begin
      p1_gnt_s = 1'b0;
      p2_gnt_s = 1'b0;
    end

    case (state_r)
      S_INIT: begin
        mem_addr_s  = init_addr_r;
        mem_we_s    = !rst;
        mem_wdata_s = init_cell(init_addr_r);
        if ((init_addr_r == ADDR_LAST) && !i_clear) begin
          state_s = S_RUN;
        end else begin
          state_s = S_INIT;
        end
      end
      S_RUN: begin
        if (i_clear) begin
          state_s = S_INIT;
        end else begin
          state_s = S_RUN;
        end
        // Out-of-range writes are acknowledged but never reach the RAM.
        if (i_vga_busy) begin
          mem_addr_s = {i_vga_y, i_vga_x};
        end else if (p1_gnt_s) begin
          mem_addr_s  = {i_p1_y, i_p1_x};
          mem_we_s    = i_p1_we && !p1_oor_s;
          mem_wdata_s = i_p1_wdata;
        end else if (p2_gnt_s) begin
          mem_addr_s  = {i_p2_y, i_p2_x};
          mem_we_s    = i_p2_we && !p2_oor_s;
          mem_wdata_s = i_p2_wdata;
        end else begin
          mem_addr_s = {ADDR_W{1'b0}};
        end
      end
      default: begin
        state_s = S_INIT;
      end
    endcase
  end

  // Control state, init sequencer, round-robin pointer and read-return pipeline.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= S_INIT;
      init_addr_r <= {ADDR_W{1'b0}};
      init_done_r <= 1'b0;
      last_p2_r   <= 1'b1;
      p1_rv_r     <= 1'b0;
      p2_rv_r     <= 1'b0;
      p1_oor_r    <= 1'b0;
      p2_oor_r    <= 1'b0;
      vga_pend_r  <= 1'b0;
    end else begin
      state_r     <= state_s;
      init_done_r <= (state_s == S_RUN);
      if (i_clear) begin
        init_addr_r <= {ADDR_W{1'b0}};
      end else if (state_r == S_INIT) begin
        init_addr_r <= init_addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
      end else begin
        init_addr_r <= init_addr_r;
      end
      if (p1_gnt_s) begin
        last_p2_r <= 1'b0;
      end else if (p2_gnt_s) begin
        last_p2_r <= 1'b1;
      end else begin
        last_p2_r <= last_p2_r;
      end
      p1_rv_r    <= p1_gnt_s && !i_p1_we;
      p2_rv_r    <= p2_gnt_s && !i_p2_we;
      p1_oor_r   <= p1_oor_s;
      p2_oor_r   <= p2_oor_s;
      vga_pend_r <= (state_r == S_RUN) && i_vga_busy;
    end
  end

  // Wall flag captures the RAM word one cycle after a VGA address was driven.
  always_ff @(posedge clk) begin
    if (rst) begin
      vga_is_wall_r <= 1'b0;
    end else if (state_s == S_INIT) begin
      vga_is_wall_r <= 1'b0;
    end else if (vga_pend_r) begin
      vga_is_wall_r <= (i_mem_rdata == CELL_WALL);
    end else begin
      vga_is_wall_r <= vga_is_wall_r;
    end
  end

  assign o_init_done   = init_done_r;
  assign o_vga_is_wall = vga_is_wall_r;
  assign o_p1_ready    = p1_gnt_s;
  assign o_p2_ready    = p2_gnt_s;
  assign o_p1_rvalid   = p1_rv_r;
  assign o_p2_rvalid   = p2_rv_r;
  assign o_p1_rdata    = (p1_rv_r && !p1_oor_r) ? i_mem_rdata : CELL_EMPTY;
  assign o_p2_rdata    = (p2_rv_r && !p2_oor_r) ? i_mem_rdata : CELL_EMPTY;
  assign o_mem_addr    = mem_addr_s;
  assign o_mem_we      = mem_we_s;
  assign o_mem_wdata   = mem_wdata_s;

endmodule

// File: tb/tb_map_access_arbiter.sv
// Directed bench for map_access_arbiter: external RAM model, a per-cycle reference model of
// the map contents and access rules, and literal checks from the test plan.
module tb_map_access_arbiter;

  logic        clk;
  logic        rst;
  logic        i_clear;
  logic        o_init_done;
  logic        i_vga_busy;
  logic [5:0]  i_vga_x, i_vga_y;
  logic        o_vga_is_wall;
  logic        i_p1_valid, i_p1_we;
  logic [5:0]  i_p1_x, i_p1_y;
  logic [1:0]  i_p1_wdata;
  logic        o_p1_ready, o_p1_rvalid;
  logic [1:0]  o_p1_rdata;
  logic        i_p2_valid, i_p2_we;
  logic [5:0]  i_p2_x, i_p2_y;
  logic [1:0]  i_p2_wdata;
  logic        o_p2_ready, o_p2_rvalid;
  logic [1:0]  o_p2_rdata;
  logic [11:0] o_mem_addr;
  logic        o_mem_we;
  logic [1:0]  o_mem_wdata;
  logic [1:0]  i_mem_rdata;

  map_access_arbiter dut (
    .clk(clk), .rst(rst), .i_clear(i_clear), .o_init_done(o_init_done),
    .i_vga_busy(i_vga_busy), .i_vga_x(i_vga_x), .i_vga_y(i_vga_y), .o_vga_is_wall(o_vga_is_wall),
    .i_p1_valid(i_p1_valid), .i_p1_we(i_p1_we), .i_p1_x(i_p1_x), .i_p1_y(i_p1_y),
    .i_p1_wdata(i_p1_wdata), .o_p1_ready(o_p1_ready), .o_p1_rvalid(o_p1_rvalid), .o_p1_rdata(o_p1_rdata),
    .i_p2_valid(i_p2_valid), .i_p2_we(i_p2_we), .i_p2_x(i_p2_x), .i_p2_y(i_p2_y),
    .i_p2_wdata(i_p2_wdata), .o_p2_ready(o_p2_ready), .o_p2_rvalid(o_p2_rvalid), .o_p2_rdata(o_p2_rdata),
    .o_mem_addr(o_mem_addr), .o_mem_we(o_mem_we), .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port RAM with one-cycle read latency.
  logic [1:0] ram [4096];
  always @(posedge clk) begin
    if (o_mem_we) ram[o_mem_addr] <= o_mem_wdata;
    i_mem_rdata <= ram[o_mem_addr];
  end

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  logic [1:0] exp_map [4096];
  int         m_idx, m_last;
  bit         m_done, m_rv1, m_rv2, m_wall, m_vpend, m_vval;
  logic [1:0] m_rd1, m_rd2;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] border(input int idx);
    int x, y;
    x = idx % 64;
    y = idx / 64;
    if (y < 44 && (x == 0 || x == 63 || y == 0 || y == 43)) return 2'b01;
    return 2'b00;
  endfunction

  // Check this cycle's outputs against the model, then advance the model past the next edge.
  task automatic model_step();
    int g, gx, gy;
    bit gwe, exp_we, rv1, rv2;
    logic [1:0] gwd, rd1, rd2, rdv;
    if (rst) begin
      m_done = 0; m_idx = 0; m_last = 2; m_rv1 = 0; m_rv2 = 0;
      m_wall = 0; m_vpend = 0; m_vval = 0;
      return;
    end
    chk("init_done", 32'(o_init_done), 32'(m_done));
    chk("vga_is_wall", 32'(o_vga_is_wall), 32'(m_wall));
    chk("p1_rvalid", 32'(o_p1_rvalid), 32'(m_rv1));
    chk("p2_rvalid", 32'(o_p2_rvalid), 32'(m_rv2));
    if (m_rv1) chk("p1_rdata", 32'(o_p1_rdata), 32'(m_rd1));
    if (m_rv2) chk("p2_rdata", 32'(o_p2_rdata), 32'(m_rd2));
    g = 0; rv1 = 0; rv2 = 0; rd1 = 2'b00; rd2 = 2'b00;
    if (!m_done) begin
      chk("init_we", 32'(o_mem_we), 32'd1);
      chk("init_addr", 32'(o_mem_addr), 32'(m_idx));
      chk("init_wdata", 32'(o_mem_wdata), 32'(border(m_idx)));
      chk("init_p1_ready", 32'(o_p1_ready), 32'd0);
      chk("init_p2_ready", 32'(o_p2_ready), 32'd0);
    end else if (i_vga_busy) begin
      chk("vga_we", 32'(o_mem_we), 32'd0);
      chk("vga_addr", 32'(o_mem_addr), 32'(int'(i_vga_y) * 64 + int'(i_vga_x)));
      chk("busy_p1_ready", 32'(o_p1_ready), 32'd0);
      chk("busy_p2_ready", 32'(o_p2_ready), 32'd0);
    end else begin
      if (i_p1_valid && i_p2_valid) g = (m_last == 2) ? 1 : 2;
      else if (i_p1_valid) g = 1;
      else if (i_p2_valid) g = 2;
      chk("p1_ready", 32'(o_p1_ready), 32'(g == 1));
      chk("p2_ready", 32'(o_p2_ready), 32'(g == 2));
      exp_we = 0;
      if (g != 0) begin
        gx  = (g == 1) ? int'(i_p1_x) : int'(i_p2_x);
        gy  = (g == 1) ? int'(i_p1_y) : int'(i_p2_y);
        gwe = (g == 1) ? i_p1_we : i_p2_we;
        gwd = (g == 1) ? i_p1_wdata : i_p2_wdata;
        m_last = g;
        if (gwe && gy < 44) begin
          exp_we = 1;
          chk("wr_addr", 32'(o_mem_addr), 32'(gy * 64 + gx));
          chk("wr_data", 32'(o_mem_wdata), 32'(gwd));
          exp_map[gy * 64 + gx] = gwd;
        end else if (!gwe) begin
          rdv = (gy < 44) ? exp_map[gy * 64 + gx] : 2'b00;
          if (g == 1) begin rv1 = 1; rd1 = rdv; end
          else begin rv2 = 1; rd2 = rdv; end
        end
      end
      chk("run_we", 32'(o_mem_we), 32'(exp_we));
    end
    if (!m_done) begin
      exp_map[m_idx] = border(m_idx);
      if (i_clear) m_idx = 0;
      else if (m_idx == 4095) m_done = 1;
      else m_idx++;
      m_wall = 0; m_vpend = 0;
    end else begin
      if (i_clear) begin m_done = 0; m_idx = 0; m_wall = 0; end
      else if (m_vpend) m_wall = m_vval;
      m_vpend = i_vga_busy;
      m_vval  = (exp_map[int'(i_vga_y) * 64 + int'(i_vga_x)] == 2'b01);
    end
    m_rv1 = rv1; m_rd1 = rd1; m_rv2 = rv2; m_rd2 = rd2;
  endtask

  task automatic tick();
    @(negedge clk);
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic p_set(input int who, input bit v, input bit we, input int x, input int y, input logic [1:0] wd);
    if (who == 1) begin
      i_p1_valid = v; i_p1_we = we; i_p1_x = 6'(x); i_p1_y = 6'(y); i_p1_wdata = wd;
    end else begin
      i_p2_valid = v; i_p2_we = we; i_p2_x = 6'(x); i_p2_y = 6'(y); i_p2_wdata = wd;
    end
  endtask

  task automatic p_read(input int who, input int x, input int y, input logic [1:0] exp, input string nm);
    int n;
    n = 0;
    p_set(who, 1'b1, 1'b0, x, y, 2'b00);
    #1;
    while (!((who == 1) ? o_p1_ready : o_p2_ready) && n < 200) begin tick(); n++; end
    chk({nm, "_wait"}, 32'(n), 32'd0);
    tick();
    p_set(who, 1'b0, 1'b0, 0, 0, 2'b00);
    chk({nm, "_rvalid"}, 32'((who == 1) ? o_p1_rvalid : o_p2_rvalid), 32'd1);
    chk({nm, "_rdata"}, 32'((who == 1) ? o_p1_rdata : o_p2_rdata), 32'(exp));
  endtask

  task automatic p_write(input int who, input int x, input int y, input logic [1:0] wd, input bit exp_we, input string nm);
    p_set(who, 1'b1, 1'b1, x, y, wd);
    #1;
    chk({nm, "_ready"}, 32'((who == 1) ? o_p1_ready : o_p2_ready), 32'd1);
    chk({nm, "_mem_we"}, 32'(o_mem_we), 32'(exp_we));
    tick();
    p_set(who, 1'b0, 1'b0, 0, 0, 2'b00);
  endtask

  initial begin
    int cyc, n;
    rst = 1'b1; i_clear = 1'b0; i_vga_busy = 1'b0; i_vga_x = 6'd0; i_vga_y = 6'd0;
    p_set(1, 1'b0, 1'b0, 0, 0, 2'b00);
    p_set(2, 1'b0, 1'b0, 0, 0, 2'b00);
    tick(); tick();
    rst = 1'b0;
    chk("done_at_reset", 32'(o_init_done), 32'd0);
    chk("wall_at_reset", 32'(o_vga_is_wall), 32'd0);
    cyc = 1;
    while (!o_init_done && cyc < 5000) begin tick(); cyc++; end
    chk("init_done_cycle", 32'(cyc), 32'd4097);

    p_read(1, 0, 5, 2'b01, "rd_0_5");
    p_read(1, 10, 10, 2'b00, "rd_10_10");
    p_read(1, 63, 43, 2'b01, "rd_63_43");
    p_read(1, 5, 44, 2'b00, "rd_5_44");

    i_vga_busy = 1'b1; i_vga_x = 6'd0; i_vga_y = 6'd0;
    tick();
    i_vga_x = 6'd10; i_vga_y = 6'd10;
    tick();
    chk("vga_wall_0_0", 32'(o_vga_is_wall), 32'd1);
    tick();
    chk("vga_wall_10_10", 32'(o_vga_is_wall), 32'd0);
    i_vga_busy = 1'b0;
    tick();

    p_write(1, 20, 20, 2'b01, 1'b1, "wr_20_20");
    p_read(2, 20, 20, 2'b01, "p2_rd_20_20");

    p_set(1, 1'b1, 1'b0, 0, 5, 2'b00);
    p_set(2, 1'b1, 1'b0, 10, 10, 2'b00);
    #1;
    for (int k = 0; k < 4; k++) begin
      chk("alt_p1_ready", 32'(o_p1_ready), 32'(k % 2 == 0));
      chk("alt_p2_ready", 32'(o_p2_ready), 32'(k % 2 == 1));
      if (k > 0) begin
        chk("alt_p1_rvalid", 32'(o_p1_rvalid), 32'(k % 2 == 1));
        chk("alt_p2_rvalid", 32'(o_p2_rvalid), 32'(k % 2 == 0));
      end
      tick();
    end
    p_set(1, 1'b0, 1'b0, 0, 0, 2'b00);
    p_set(2, 1'b0, 1'b0, 0, 0, 2'b00);
    chk("alt_last_rvalid", 32'(o_p2_rvalid), 32'd1);
    chk("alt_last_rdata", 32'(o_p2_rdata), 32'd0);
    tick();

    i_vga_busy = 1'b1;
    p_set(1, 1'b1, 1'b0, 20, 20, 2'b00);
    #1;
    for (int k = 0; k < 100; k++) begin
      chk("busy_hold_ready", 32'(o_p1_ready), 32'd0);
      tick();
    end
    i_vga_busy = 1'b0;
    #1;
    chk("busy_release_ready", 32'(o_p1_ready), 32'd1);
    tick();
    p_set(1, 1'b0, 1'b0, 0, 0, 2'b00);
    chk("busy_release_rdata", 32'(o_p1_rdata), 32'd1);

    p_write(2, 30, 30, 2'b11, 1'b1, "wr_reserved");
    p_read(1, 30, 30, 2'b11, "rd_reserved");

    i_clear = 1'b1;
    tick();
    i_clear = 1'b0;
    chk("clear_done_drop", 32'(o_init_done), 32'd0);
    p_set(1, 1'b1, 1'b0, 20, 20, 2'b00);
    #1;
    n = 0;
    while (!o_p1_ready && n < 6000) begin tick(); n++; end
    chk("clear_wait", 32'(n), 32'd4096);
    tick();
    p_set(1, 1'b0, 1'b0, 0, 0, 2'b00);
    chk("clear_rd_rvalid", 32'(o_p1_rvalid), 32'd1);
    chk("clear_rd_rdata", 32'(o_p1_rdata), 32'd0);
    p_write(1, 5, 50, 2'b01, 1'b0, "wr_oor");
    p_read(2, 5, 50, 2'b00, "rd_oor");

    p_set(1, 1'b1, 1'b0, 0, 5, 2'b00);
    rst = 1'b1;
    tick();
    p_set(1, 1'b0, 1'b0, 0, 0, 2'b00);
    chk("rst_mid_rvalid", 32'(o_p1_rvalid), 32'd0);
    chk("rst_mid_done", 32'(o_init_done), 32'd0);
    rst = 1'b0;
    for (int k = 0; k < 8; k++) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
